// File: rtl/cpu_pkg.sv
// Shared opcode/phase definitions for the controller and the ALU.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes whose result lands in the accumulator via alu_out.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from phase, halted flag, opcode and zero.
module ctrl_decode
  import cpu_pkg::*;
(
  input  phase_e     i_phase,
  input  logic       i_halted,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  output logic       o_sel,
  output logic       o_rd,
  output logic       o_ld_ir,
  output logic       o_inc_pc,
  output logic       o_ld_pc,
  output logic       o_ld_ac,
  output logic       o_wr,
  output logic       o_data_e,
  output logic       o_halt
);

  logic w_aluop;
  logic w_is_sto;
  logic w_is_jmp;

  assign w_aluop  = is_aluop(i_opcode);
  assign w_is_sto = (i_opcode == OP_STO);
  assign w_is_jmp = (i_opcode == OP_JMP);

  always_comb begin
    o_sel    = 1'b0;
    o_rd     = 1'b0;
    o_ld_ir  = 1'b0;
    o_inc_pc = 1'b0;
    o_ld_pc  = 1'b0;
    o_ld_ac  = 1'b0;
    o_wr     = 1'b0;
    o_data_e = 1'b0;
    o_halt   = 1'b0;
    if (i_halted) begin
      o_halt = 1'b1;
    end else begin
      unique case (i_phase)
        INST_ADDR: begin
          o_sel = 1'b1;
        end
        INST_FETCH: begin
          o_sel = 1'b1;
          o_rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          o_sel   = 1'b1;
          o_rd    = 1'b1;
          o_ld_ir = 1'b1;
        end
        OP_ADDR: begin
          o_inc_pc = 1'b1;
          o_halt   = (i_opcode == OP_HLT);
        end
        OP_FETCH: begin
          o_rd = w_aluop;
        end
        ALU_OP: begin
          o_rd     = w_aluop;
          o_inc_pc = (i_opcode == OP_SKZ) && i_zero;
          o_ld_pc  = w_is_jmp;
          o_data_e = w_is_sto;
        end
        STORE: begin
          o_rd     = w_aluop;
          o_ld_ac  = w_aluop;
          o_inc_pc = w_is_jmp;
          o_ld_pc  = w_is_jmp;
          o_wr     = w_is_sto;
          o_data_e = w_is_sto;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase CPU sequencer: phase counter plus halted flag, decode in ctrl_decode.
// Optional CPU_CTRL_RESUME_EN adds a resume input that leaves the halted state.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef CPU_CTRL_RESUME_EN
  input  logic       resume,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  phase_e r_phase;
  logic   r_halted;
  phase_e w_phase_nxt;
  logic   w_halted_nxt;
  logic   w_resume;
  phase_e w_phase_eff;
  logic   w_halted_eff;

`ifdef CPU_CTRL_RESUME_EN
  assign w_resume = resume;
`else
  assign w_resume = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = phase_e'(r_phase + 3'd1);
    w_halted_nxt = r_halted;
    if (r_halted) begin
      if (w_resume) begin
        w_phase_nxt  = INST_ADDR;
        w_halted_nxt = 1'b0;
      end else begin
        w_phase_nxt = r_phase;
      end
    end else if ((r_phase == OP_ADDR) && (opcode == OP_HLT)) begin
      w_phase_nxt  = r_phase;
      w_halted_nxt = 1'b1;
    end
  end

  // While rst is high the outputs already show the phase-0 decode.
  assign w_phase_eff  = rst ? INST_ADDR : r_phase;
  assign w_halted_eff = rst ? 1'b0 : r_halted;
  assign phase        = w_phase_eff;

  ctrl_decode u_ctrl_decode (
    .i_phase  (w_phase_eff),
    .i_halted (w_halted_eff),
    .i_opcode (opcode),
    .i_zero   (zero),
    .o_sel    (sel),
    .o_rd     (rd),
    .o_ld_ir  (ld_ir),
    .o_inc_pc (inc_pc),
    .o_ld_pc  (ld_pc),
    .o_ld_ac  (ld_ac),
    .o_wr     (wr),
    .o_data_e (data_e),
    .o_halt   (halt)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed scenarios plus random stimulus against a phase/halt model.
module tb_cpu_controller;

`ifdef CPU_CTRL_RESUME_EN
  localparam bit ResumeEn = 1'b1;
  logic resume;
`else
  localparam bit ResumeEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;
  int m_ph   = 0;
  bit m_hlt  = 1'b0;
  int n_wr, n_ldac, n_incpc, n_ldpc, n_de;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CPU_CTRL_RESUME_EN
    .resume (resume),
`endif
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase[2:0]}.
  function automatic logic [11:0] model_out(bit r, logic [2:0] op, bit z);
    int ph = r ? 0 : m_ph;
    bit h  = r ? 1'b0 : m_hlt;
    bit alu = (op >= 3'd2) && (op <= 3'd5);
    bit e_sel = 0, e_rd = 0, e_ir = 0, e_inc = 0, e_ldpc = 0;
    bit e_ldac = 0, e_wr = 0, e_de = 0, e_halt = 0;
    logic [2:0] ph3 = ph[2:0];
    if (h) begin
      e_halt = 1;
    end else begin
      case (ph)
        0: e_sel = 1;
        1: begin e_sel = 1; e_rd = 1; end
        2, 3: begin e_sel = 1; e_rd = 1; e_ir = 1; end
        4: begin e_inc = 1; e_halt = (op == 3'd0); end
        5: e_rd = alu;
        6: begin
          e_rd = alu; e_inc = (op == 3'd1) && z; e_ldpc = (op == 3'd7); e_de = (op == 3'd6);
        end
        default: begin
          e_rd = alu; e_ldac = alu; e_inc = (op == 3'd7); e_ldpc = (op == 3'd7);
          e_wr = (op == 3'd6); e_de = (op == 3'd6);
        end
      endcase
    end
    return {e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, ph3};
  endfunction

  task automatic model_step(bit r, logic [2:0] op, bit res);
    if (r) begin
      m_ph = 0; m_hlt = 0;
    end else if (m_hlt) begin
      if (res && ResumeEn) begin m_ph = 0; m_hlt = 0; end
    end else if (m_ph == 4 && op == 3'd0) begin
      m_hlt = 1;
    end else begin
      m_ph = (m_ph + 1) % 8;
    end
  endtask

  task automatic clr_counts();
    n_wr = 0; n_ldac = 0; n_incpc = 0; n_ldpc = 0; n_de = 0;
  endtask

  // One clock: drive, check outputs mid-cycle, advance model on the edge.
  task automatic cyc(bit r, logic [2:0] op, bit z, bit res, string tag);
    logic [11:0] exp_v, obs_v;
    rst = r; opcode = op; zero = z;
`ifdef CPU_CTRL_RESUME_EN
    resume = res;
`endif
    #3;
    exp_v = model_out(r, op, z);
    obs_v = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: model_ph=%0d observed=%b expected=%b", tag, m_ph, obs_v, exp_v);
    end
    n_wr += int'(wr); n_ldac += int'(ld_ac); n_incpc += int'(inc_pc);
    n_ldpc += int'(ld_pc); n_de += int'(data_e);
    @(posedge clk);
    model_step(r, op, res);
    #1;
  endtask

  task automatic check_val(string tag, int obs, int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Full instruction from phase 0; opcode random while it is don't-care.
  task automatic run_instr(logic [2:0] op, bit z, string tag);
    for (int p = 0; p < 8; p++) begin
      logic [2:0] cop = (p < 4) ? 3'($urandom) : op;
      bit cz = (p == 6) ? z : 1'($urandom);
      cyc(1'b0, cop, cz, 1'b0, tag);
    end
  endtask

  initial begin
    logic [2:0] cur_op;
    rst = 1'b1; opcode = 3'd0; zero = 1'b0;
`ifdef CPU_CTRL_RESUME_EN
    resume = 1'b0;
`endif
    cyc(1'b1, 3'($urandom), 1'($urandom), 1'b0, "reset");
    cyc(1'b1, 3'($urandom), 1'($urandom), 1'b0, "reset");
    check_val("reset_phase0", int'(phase), 0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 3'd2, 1'b0, 1'b0, "post_reset");
    check_val("phase_reaches_7", int'(phase), 7);
    cyc(1'b0, 3'd2, 1'b0, 1'b0, "post_reset");

    clr_counts();
    run_instr(3'd2, 1'b1, "add");
    check_val("add_ld_ac_count", n_ldac, 1);
    check_val("add_wr_count", n_wr, 0);

    clr_counts();
    run_instr(3'd6, 1'b0, "sto");
    check_val("sto_wr_count", n_wr, 1);
    check_val("sto_data_e_count", n_de, 2);
    check_val("sto_ld_ac_count", n_ldac, 0);

    clr_counts();
    run_instr(3'd1, 1'b1, "skz_taken");
    check_val("skz_taken_inc_pc", n_incpc, 2);
    clr_counts();
    run_instr(3'd1, 1'b0, "skz_not_taken");
    check_val("skz_not_taken_inc_pc", n_incpc, 1);

    clr_counts();
    run_instr(3'd7, 1'b0, "jmp");
    check_val("jmp_ld_pc", n_ldpc, 2);
    check_val("jmp_inc_pc", n_incpc, 2);

    // STO aborted by reset in phase 6: no write may follow.
    clr_counts();
    for (int p = 0; p < 6; p++) cyc(1'b0, 3'd6, 1'b0, 1'b0, "sto_abort");
    cyc(1'b1, 3'd6, 1'b0, 1'b0, "sto_abort_rst");
    run_instr(3'd5, 1'b0, "lda_after_abort");
    check_val("abort_wr_count", n_wr, 0);

    for (int p = 0; p < 5; p++) cyc(1'b0, (p == 4) ? 3'd0 : 3'($urandom), 1'b0, 1'b0, "hlt");
    for (int i = 0; i < 20; i++) cyc(1'b0, 3'($urandom), 1'($urandom), 1'b0, "halted");
    check_val("halt_frozen_phase", int'(phase), 4);
    check_val("halt_flag", int'(halt), 1);
    cyc(1'b1, 3'd0, 1'b0, 1'b0, "halt_rst");
    check_val("halt_rst_phase", int'(phase), 0);
    check_val("halt_rst_halt", int'(halt), 0);

    if (ResumeEn) begin
      for (int p = 0; p < 5; p++) cyc(1'b0, 3'd0, 1'b0, 1'b0, "hlt2");
      for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 1'b0, 1'b0, "halted2");
      cyc(1'b0, 3'd0, 1'b0, 1'b1, "resume");
      check_val("resume_phase", int'(phase), 0);
      check_val("resume_halt", int'(halt), 0);
    end

    cur_op = 3'd2;
    for (int i = 0; i < 400; i++) begin
      bit r   = ($urandom_range(0, 39) == 0) || (m_hlt && $urandom_range(0, 7) == 0);
      bit res = ($urandom_range(0, 5) == 0);
      if (m_ph == 0) cur_op = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      cyc(r, (m_ph < 4) ? 3'($urandom) : cur_op, 1'($urandom), res, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
